// File: rtl/bus_swap_unit.sv
// Bus-based register file with a hidden temp register.
// A small FSM moves values over one shared bus to copy or swap registers.
module bus_swap_unit #(
    parameter int N = 8,
    parameter int K = 4,
    parameter int S = 2
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         Start,
    input  logic         Op,
    input  logic [S-1:0] Src,
    input  logic [S-1:0] Dst,
    input  logic [N-1:0] Data,
    input  logic         ExtLoad,
    input  logic [S-1:0] ExtSel,
    input  logic [S-1:0] RdSel,
    output logic [N-1:0] RdData,
    output logic [N-1:0] BusWires,
    output logic         Busy,
    output logic         Done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        C1   = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        S3   = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_regs [K];
    logic [N-1:0]   r_temp;
    logic           r_op;
    logic [S-1:0]   r_src;
    logic [S-1:0]   r_dst;

    logic [N-1:0]   w_bus;
    logic           w_wen;
    logic [S-1:0]   w_widx;
    logic           w_tload;
    logic           w_latch;
    logic           w_done;

    // Indices at or above K have no register behind them and read as zero.
    function automatic logic [N-1:0] f_rd(input logic [S-1:0] sel);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < K; i++) begin
            if (sel == S'(i)) begin
                v = r_regs[i];
            end
        end
        return v;
    endfunction

    // State register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, bus source and the single write port for this cycle.
    always_comb begin
        w_next  = r_state;
        w_bus   = Data;
        w_wen   = 1'b0;
        w_widx  = r_dst;
        w_tload = 1'b0;
        w_latch = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (Start) begin
                    w_latch = 1'b1;
                    w_next  = Op ? S1 : C1;
                end else if (ExtLoad) begin
                    w_wen  = 1'b1;
                    w_widx = ExtSel;
                end
            end
            C1: begin
                w_bus  = f_rd(r_src);
                w_wen  = 1'b1;
                w_widx = r_dst;
                w_done = 1'b1;
                w_next = IDLE;
            end
            S1: begin
                w_bus   = f_rd(r_src);
                w_tload = 1'b1;
                w_next  = S2;
            end
            S2: begin
                w_bus  = f_rd(r_dst);
                w_wen  = 1'b1;
                w_widx = r_src;
                w_next = S3;
            end
            S3: begin
                w_bus  = r_temp;
                w_wen  = 1'b1;
                w_widx = r_dst;
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operation fields are captured once at Start and held while busy.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_op  <= 1'b0;
            r_src <= '0;
            r_dst <= '0;
        end else if (w_latch) begin
            r_op  <= Op;
            r_src <= Src;
            r_dst <= Dst;
        end
    end

    // Temp register holds the first swap operand.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_temp <= '0;
        end else if (w_tload) begin
            r_temp <= w_bus;
        end
    end

    // User registers; out-of-range write indices match nothing.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < K; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wen) begin
            for (int i = 0; i < K; i++) begin
                if (w_widx == S'(i)) begin
                    r_regs[i] <= w_bus;
                end
            end
        end
    end

    // Outputs.
    always_comb begin
        RdData   = f_rd(RdSel);
        BusWires = w_bus;
        Busy     = (r_state != IDLE);
        Done     = w_done;
    end

    // The latched op is implied by the state path; kept for visibility.
    logic w_op_unused;
    assign w_op_unused = r_op;

endmodule

// File: tb/tb_bus_swap_unit.sv
// Testbench for bus_swap_unit: directed plan plus random ops,
// run on a full (K=4) and a partial (K=3) register file.
module tb_bus_swap_unit;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       Start = 1'b0;
    logic       Op = 1'b0;
    logic       ExtLoad = 1'b0;
    logic [1:0] Src = '0;
    logic [1:0] Dst = '0;
    logic [1:0] ExtSel = '0;
    logic [1:0] RdSel = '0;
    logic [7:0] Data = 8'h5A;

    logic [7:0] RdData_a, Bus_a, RdData_b, Bus_b;
    logic       Busy_a, Done_a, Busy_b, Done_b;

    int checks = 0;
    int failures = 0;

    logic [7:0] ma [4];
    logic [7:0] mb [4];

    bus_swap_unit #(.N(8), .K(4), .S(2)) u_a (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Op(Op),
        .Src(Src), .Dst(Dst), .Data(Data), .ExtLoad(ExtLoad),
        .ExtSel(ExtSel), .RdSel(RdSel), .RdData(RdData_a),
        .BusWires(Bus_a), .Busy(Busy_a), .Done(Done_a)
    );

    bus_swap_unit #(.N(8), .K(3), .S(2)) u_b (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Op(Op),
        .Src(Src), .Dst(Dst), .Data(Data), .ExtLoad(ExtLoad),
        .ExtSel(ExtSel), .RdSel(RdSel), .RdData(RdData_b),
        .BusWires(Bus_b), .Busy(Busy_b), .Done(Done_b)
    );

    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Model: a register file of K entries; index >= K reads 0, ignores writes.
    function automatic logic [7:0] mrd(input int k, input int i);
        if (k == 4) return ma[i];
        return (i < 3) ? mb[i] : 8'h00;
    endfunction

    task automatic mwr(input int k, input int i, input logic [7:0] v);
        if (k == 4) ma[i] = v;
        else if (i < 3) mb[i] = v;
    endtask

    task automatic mclear();
        for (int i = 0; i < 4; i++) begin
            ma[i] = 8'h00;
            mb[i] = 8'h00;
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            RdSel = 2'(i);
            #1;
            chk($sformatf("%s_a_R%0d", tag, i), RdData_a, mrd(4, i));
            chk($sformatf("%s_b_R%0d", tag, i), RdData_b, mrd(3, i));
        end
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, "_busy_a"}, Busy_a, 1'b0);
        chk1({tag, "_busy_b"}, Busy_b, 1'b0);
        chk1({tag, "_done_a"}, Done_a, 1'b0);
        chk1({tag, "_done_b"}, Done_b, 1'b0);
        chk({tag, "_bus_a"}, Bus_a, Data);
        chk({tag, "_bus_b"}, Bus_b, Data);
    endtask

    task automatic ext_load(input int sel, input logic [7:0] val);
        ExtSel  = 2'(sel);
        Data    = val;
        ExtLoad = 1'b1;
        #1;
        chk_idle("ld");
        tick();
        ExtLoad = 1'b0;
        mwr(4, sel, val);
        mwr(3, sel, val);
        chk_regs("ld");
    endtask

    // Runs one op; while busy the control inputs are scrambled.
    task automatic do_op(input logic op, input int s, input int d,
                         input logic extl);
        logic [7:0] sa, da, sb, db;
        logic [7:0] ea [3];
        logic [7:0] eb [3];
        logic       ed [3];
        int n;
        sa = mrd(4, s);
        da = mrd(4, d);
        sb = mrd(3, s);
        db = mrd(3, d);
        if (!op) begin
            n = 1;
            ea[0] = sa; eb[0] = sb; ed[0] = 1'b1;
        end else begin
            n = 3;
            ea[0] = sa; eb[0] = sb; ed[0] = 1'b0;
            ea[1] = da; eb[1] = db; ed[1] = 1'b0;
            ea[2] = sa; eb[2] = sb; ed[2] = 1'b1;
        end
        Start = 1'b1;
        Op    = op;
        Src   = 2'(s);
        Dst   = 2'(d);
        if (extl) begin
            ExtLoad = 1'b1;
            ExtSel  = 2'd0;
            Data    = 8'hFF;
        end
        tick();
        Start   = 1'b0;
        ExtLoad = 1'b0;
        for (int c = 0; c < n; c++) begin
            chk1($sformatf("op_busy_a_c%0d", c), Busy_a, 1'b1);
            chk1($sformatf("op_busy_b_c%0d", c), Busy_b, 1'b1);
            chk1($sformatf("op_done_a_c%0d", c), Done_a, ed[c]);
            chk1($sformatf("op_done_b_c%0d", c), Done_b, ed[c]);
            chk($sformatf("op_bus_a_c%0d", c), Bus_a, ea[c]);
            chk($sformatf("op_bus_b_c%0d", c), Bus_b, eb[c]);
            Start   = 1'($urandom);
            ExtLoad = 1'b1;
            ExtSel  = 2'($urandom);
            Op      = 1'($urandom);
            Src     = 2'($urandom);
            Dst     = 2'($urandom);
            Data    = 8'($urandom);
            tick();
            Start   = 1'b0;
            ExtLoad = 1'b0;
        end
        if (!op) begin
            mwr(4, d, sa);
            mwr(3, d, sb);
        end else begin
            mwr(4, s, da);
            mwr(4, d, sa);
            mwr(3, s, db);
            mwr(3, d, sb);
        end
        #1;
        chk_idle("post");
        chk_regs("post");
    endtask

    initial begin
        mclear();
        #2;
        chk_idle("rst");
        chk_regs("rst");
        #14;
        Resetn = 1'b1;
        tick();
        chk_idle("rel");

        ext_load(0, 8'h11);
        ext_load(1, 8'h22);
        ext_load(2, 8'h33);
        ext_load(3, 8'h44);

        do_op(1'b1, 1, 3, 1'b0);
        do_op(1'b0, 0, 2, 1'b0);
        do_op(1'b1, 2, 3, 1'b1);
        do_op(1'b1, 2, 2, 1'b0);
        do_op(1'b1, 0, 1, 1'b0);
        do_op(1'b0, 3, 0, 1'b0);
        do_op(1'b1, 3, 1, 1'b0);

        // Reset in S2 of a swap.
        ext_load(0, 8'hA5);
        ext_load(1, 8'h5C);
        Start = 1'b1;
        Op    = 1'b1;
        Src   = 2'd0;
        Dst   = 2'd1;
        tick();
        Start = 1'b0;
        tick();
        chk1("s2_busy", Busy_a, 1'b1);
        Resetn = 1'b0;
        #1;
        mclear();
        chk_idle("arst");
        chk_regs("arst");
        Resetn = 1'b1;
        tick();
        chk_idle("arst_after");
        ext_load(2, 8'h77);
        do_op(1'b0, 2, 1, 1'b0);

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                ext_load(int'($urandom_range(0, 3)), 8'($urandom));
            end else begin
                do_op(1'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_swap_unit.md
Name: bus_swap_unit

Overview:
- Parametrised bus-based register file of K N-bit registers plus one hidden temp register, driven by a single shared bus.
- An FSM moves values between registers over the bus, one transfer per cycle.
- Supports two operations, each on any register pair: swap (three transfers through the temp) and copy (one transfer).
- Sits as the datapath/control building block under a simple processor-style controller.

Parameters:
- N, 8, register and bus width in bits.
- K, 4, number of user registers R[0..K-1], 2 <= K <= 2**S.
- S, 2, width of the register select fields.

Ports:
- Clock  input  1  rising-edge clock
- Resetn  input  1  asynchronous active-low reset
- Start  input  1  request an operation; sampled only in IDLE
- Op  input  1  0 = copy R[Src] to R[Dst], 1 = swap R[Src] and R[Dst]
- Src  input  S  source register select
- Dst  input  S  destination register select
- Data  input  N  external data driven onto the bus in IDLE
- ExtLoad  input  1  load R[ExtSel] from Data; honoured only in IDLE
- ExtSel  input  S  register select for ExtLoad
- RdSel  input  S  register select for the combinational read port
- RdData  output  N  R[RdSel], combinational; 0 if RdSel >= K
- BusWires  output  N  current bus value
- Busy  output  1  high whenever the state is not IDLE
- Done  output  1  high during the final transfer cycle of an operation

Behaviour:
- Reset (Resetn=0, asynchronous):
  - State goes to IDLE.
  - All R[i] and the temp T clear to 0; the latched select and op fields clear to 0.
  - Busy=0, Done=0, BusWires=Data.
  - Reset mid-operation aborts the operation; the partial transfer is discarded.
- States: IDLE, C1, S1, S2, S3 (binary encoded).
- IDLE:
  - BusWires=Data.
  - Start=1 latches Op, Src and Dst. Next state is C1 if Op=0, else S1.
  - Otherwise, ExtLoad=1 writes R[ExtSel] <= Data.
  - Start and ExtLoad in the same cycle: Start wins and ExtLoad is dropped.
- C1 (copy): BusWires=R[Src]; R[Dst] <= bus; Done=1; next state IDLE.
- S1: BusWires=R[Src]; T <= bus; next state S2.
- S2: BusWires=R[Dst]; R[Src] <= bus; next state S3.
- S3: BusWires=T; R[Dst] <= bus; Done=1; next state IDLE.
- Latency, with Start sampled at edge e0:
  - Copy: result is visible at RdData after e1.
  - Swap: result is visible after e3.
  - Done is a one-cycle pulse in the last transfer cycle (C1 or S3).
  - A new Start is accepted in the IDLE cycle immediately after; back-to-back issue gives a gap of exactly one IDLE cycle.
- While Busy: Start, ExtLoad, Src, Dst and Op changes are ignored; the latched values govern the operation.
- Src == Dst: the operation still runs its full length and register contents are unchanged.
- Select >= K (any of Src, Dst, ExtSel):
  - Writes to that index are suppressed.
  - Reads of that index drive 0 on the bus; the FSM sequence is unchanged.
- Only one register is written per cycle. The temp T is written only in S1.
- BusWires is a pure function of state, the latched selects, registers and Data (one mux, no tristates).

Test Plan:
- Reset then ExtLoad Data=0x11/0x22/0x33/0x44 into R0..R3 -> RdData reads 0x11, 0x22, 0x33, 0x44; Busy=0 throughout.
- Swap with Src=1, Dst=3 -> BusWires is 0x22, 0x44, 0x22 in S1..S3; Done only in S3; afterwards R1=0x44, R3=0x22, R0 and R2 unchanged.
- Copy with Src=0, Dst=2 -> Done in the first cycle after Start; R2=0x11; Busy high for exactly one cycle.
- Start plus ExtLoad (ExtSel=0, Data=0xFF) in the same IDLE cycle, followed by Start/ExtLoad pulses while Busy -> the operation runs; R0 stays unchanged by the dropped loads; no second operation starts.
- Swap Src=Dst=2, then back-to-back swap (0,1) issued in the IDLE cycle after Done -> R2 is unchanged after the first; R0/R1 are exchanged after the second.
- Resetn pulsed low during S2 of a swap -> all registers read 0 immediately; Busy=0; Done never asserts; the next Start runs normally.
